crc16_stream: RTL and testbench
===============================

Name: crc16_stream

Overview:
- Sequential, parametrised CRC-16 engine that computes a frame CRC over a valid/ready data stream, one DATA_W-bit beat per cycle.
- Handles a partial last beat byte-serially and reports the final CRC.
- Compares the final register against a residue, so the same block serves both the generate path and the check path.
- Sits between the packet data setup logic and the endpoint framer/deframer.

Parameters:
- DATA_W, 72, beat width in bits; multiple of 8, range 8..128.
- POLY, 16'h8005, generator polynomial (x^16+x^15+x^2+1), non-reflected.
- INIT, 16'h0000, CRC register value at start of frame.
- XOR_OUT, 16'h0000, XORed into the register to form crc_out.
- RESIDUE, 16'h0000, register value after data plus appended CRC that means "good frame".

Ports:
- clk  in  1  rising-edge clock
- reset_L  in  1  asynchronous active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  engine can accept a beat this cycle
- in_data  in  DATA_W  beat; bit DATA_W-1 enters the CRC first (MSB-first)
- in_sop  in  1  first beat of frame
- in_eop  in  1  last beat of frame
- in_nbytes  in  $clog2(DATA_W/8+1)  valid bytes on the eop beat, counted from the MSB; 0 or >DATA_W/8 means full
- crc_out  out  16  final CRC (register ^ XOR_OUT), held until next frame completes
- crc_valid  out  1  one-cycle pulse when crc_out/crc_ok update
- crc_ok  out  1  final register == RESIDUE
- abort  out  1  one-cycle pulse when an sop arrives mid-frame
- busy  out  1  frame in progress (RUN or TAIL)

Behaviour:
- Reset (async assert, sync release): state IDLE, CRC register = INIT.
  - Outputs: crc_out=0, crc_valid=0, crc_ok=0, abort=0, busy=0, in_ready=1.
- Accept: a beat transfers when in_valid & in_ready at a rising edge.
- in_ready = 1 in IDLE, RUN and DONE; 0 in TAIL.
- Full-beat update: register <= DATA_W serial LFSR steps of POLY applied to in_data, MSB-first, in one cycle (combinational unroll). On an sop beat the steps start from INIT rather than the current register.
- States:
  - IDLE: beats without in_sop are ignored (dropped, no effect).
    - Beat with sop & !eop -> RUN.
    - sop & eop, full -> DONE.
    - sop & eop, partial -> TAIL.
  - RUN: each beat updates the register.
    - eop full -> DONE.
    - eop partial -> TAIL.
    - sop mid-frame -> abort pulse; the register restarts from INIT with this beat; same eop rules apply.
  - TAIL: the accepted eop beat is latched. One byte (MSB byte first) is processed per cycle for in_nbytes cycles, 8 LFSR steps each, then -> DONE. in_ready=0 throughout.
  - DONE (one cycle): crc_out <= register^XOR_OUT, crc_ok <= (register==RESIDUE), crc_valid=1.
    - A beat accepted in DONE is handled as in IDLE, so back-to-back frames are possible.
    - Otherwise -> IDLE.
- Latency:
  - Full eop beat accepted at edge N -> crc_valid high in cycle N+1.
  - Partial eop with k bytes -> crc_valid in cycle N+k+1.
- busy = 1 in RUN and TAIL, else 0.
- crc_out and crc_ok hold their values between frames.
- in_nbytes is sampled only on the eop beat.
- Reset mid-frame discards all state; no crc_valid is generated.

Test Plan:
- DATA_W=72, single beat sop+eop, in_data=0x313233343536373839 ("123456789") -> crc_valid 1 cycle after accept, crc_out=0xFEE8, crc_ok=0.
- DATA_W=8, nine beats "1".."9", sop on first, eop on last, in_valid gapped randomly -> crc_out=0xFEE8, busy high from first accept until DONE.
- DATA_W=32, beats 0x31323334, 0x35363738, then 0x39xxxxxx with eop, in_nbytes=1 -> in_ready low 1 cycle, crc_valid 2 cycles after the last accept, crc_out=0xFEE8.
- Check mode: DATA_W=8, frame "123456789",0xFE,0xE8 -> crc_ok=1. Corrupt one data bit -> crc_ok=0.
- Abort: sop during a frame -> abort pulse, and the CRC reflects only the new frame ("123456789" -> 0xFEE8). Then assert reset_L=0 mid-frame -> all outputs 0, in_ready=1, and the following frame is correct.

Source files
------------

// File: rtl/crc16_stream_if.sv
// Beat stream into the CRC engine: valid/ready handshake with frame
// delimiters and a byte count for the final, possibly partial, beat.
interface crc16_stream_if #(
  parameter int DATA_W = 72
) ();
  localparam int NBW = $clog2(DATA_W / 8 + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [NBW-1:0]    in_nbytes;

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_nbytes,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_nbytes,
    output in_ready
  );
endinterface

// File: rtl/crc16_stream.sv
// Streaming CRC-16 engine, MSB-first, one beat per cycle. A partial eop
// beat is finished byte-serially. The final register is compared against
// RESIDUE so the block serves both the generate and the check path.
module crc16_stream #(
  parameter int          DATA_W  = 72,
  parameter logic [15:0] POLY    = 16'h8005,
  parameter logic [15:0] INIT    = 16'h0000,
  parameter logic [15:0] XOR_OUT = 16'h0000,
  parameter logic [15:0] RESIDUE = 16'h0000
) (
  input  logic                clk,
  input  logic                reset_L,
  crc16_stream_if.slave       strm,
  output logic [15:0]         crc_out,
  output logic                crc_valid,
  output logic                crc_ok,
  output logic                abort,
  output logic                busy
);
  localparam int NB  = DATA_W / 8;
  localparam int NBW = $clog2(NB + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [15:0]       crc_reg, crc_nxt, base;
  logic [NBW-1:0]    tail_cnt, tail_cnt_nxt;
  logic [DATA_W-1:0] tail_data;
  logic              accept, partial, load_tail, finish, abort_nxt;

  // Eight serial LFSR steps, MSB of the byte first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return c;
  endfunction

  // Whole beat, most significant byte first.
  function automatic logic [15:0] crc_beat(input logic [15:0] c_in, input logic [DATA_W-1:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = NB - 1; i >= 0; i--) c = crc_byte(c, d[i*8 +: 8]);
    return c;
  endfunction

  assign strm.in_ready = (state != TAIL);
  assign busy          = (state == RUN) || (state == TAIL);
  assign crc_valid     = (state == DONE);

  // Next-state, next-register and frame-completion decode.
  always_comb begin
    accept       = strm.in_valid && strm.in_ready;
    partial      = (strm.in_nbytes != '0) && (int'(strm.in_nbytes) < NB);
    state_nxt    = state;
    crc_nxt      = crc_reg;
    tail_cnt_nxt = tail_cnt;
    base         = crc_reg;
    load_tail    = 1'b0;
    finish       = 1'b0;
    abort_nxt    = 1'b0;
    case (state)
      TAIL: begin
        crc_nxt      = crc_byte(crc_reg, tail_data[DATA_W-1 -: 8]);
        tail_cnt_nxt = tail_cnt - NBW'(1);
        if (tail_cnt == NBW'(1)) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE drop beats without sop; RUN takes every beat.
        if (state != RUN) state_nxt = IDLE;
        if (accept && (strm.in_sop || state == RUN)) begin
          base      = strm.in_sop ? INIT : crc_reg;
          abort_nxt = (state == RUN) && strm.in_sop;
          if (strm.in_eop && partial) begin
            crc_nxt      = base;
            tail_cnt_nxt = strm.in_nbytes;
            load_tail    = 1'b1;
            state_nxt    = TAIL;
          end else begin
            crc_nxt = crc_beat(base, strm.in_data);
            if (strm.in_eop) begin
              state_nxt = DONE;
              finish    = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
      end
    endcase
  end

  // Control state, CRC register and held frame result.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      crc_reg  <= INIT;
      tail_cnt <= '0;
      crc_out  <= '0;
      crc_ok   <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_nxt;
      crc_reg  <= crc_nxt;
      tail_cnt <= tail_cnt_nxt;
      abort    <= abort_nxt;
      if (finish) begin
        crc_out <= crc_nxt ^ XOR_OUT;
        crc_ok  <= (crc_nxt == RESIDUE);
      end
    end
  end

  // Latched eop beat, shifted up one byte per tail cycle.
  always_ff @(posedge clk) begin
    if (load_tail)          tail_data <= strm.in_data;
    else if (state == TAIL) tail_data <= tail_data << 8;
  end
endmodule

// File: tb/tb_crc16_stream.sv
// Directed bench for crc16_stream at beat widths 72, 8 and 32.
module tb_crc16_stream;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] msg [0:8];

  always #5 clk = ~clk;

  crc16_stream_if #(.DATA_W(72)) i72 ();
  crc16_stream_if #(.DATA_W(8))  i8 ();
  crc16_stream_if #(.DATA_W(32)) i32 ();

  logic [15:0] co72, co8, co32;
  logic cv72, ok72, ab72, bz72;
  logic cv8, ok8, ab8, bz8;
  logic cv32, ok32, ab32, bz32;

  crc16_stream #(.DATA_W(72)) d72 (.clk(clk), .reset_L(reset_L), .strm(i72), .crc_out(co72),
    .crc_valid(cv72), .crc_ok(ok72), .abort(ab72), .busy(bz72));
  crc16_stream #(.DATA_W(8)) d8 (.clk(clk), .reset_L(reset_L), .strm(i8), .crc_out(co8),
    .crc_valid(cv8), .crc_ok(ok8), .abort(ab8), .busy(bz8));
  crc16_stream #(.DATA_W(32)) d32 (.clk(clk), .reset_L(reset_L), .strm(i32), .crc_out(co32),
    .crc_valid(cv32), .crc_ok(ok32), .abort(ab32), .busy(bz32));

  // Each beat is driven at a falling edge and released just after the
  // rising edge that accepts it; callers check right after return.
  task automatic beat8(input logic [7:0] d, input logic sop, input logic eop);
    @(negedge clk);
    i8.in_valid = 1'b1; i8.in_data = d; i8.in_sop = sop; i8.in_eop = eop; i8.in_nbytes = '0;
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i8.in_sop = 1'b0; i8.in_eop = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] d, input logic sop, input logic eop, input logic [2:0] nb);
    @(negedge clk);
    i32.in_valid = 1'b1; i32.in_data = d; i32.in_sop = sop; i32.in_eop = eop; i32.in_nbytes = nb;
    @(posedge clk); #1;
    i32.in_valid = 1'b0; i32.in_sop = 1'b0; i32.in_eop = 1'b0;
  endtask

  task automatic beat72(input logic [71:0] d, input logic sop, input logic eop, input logic [3:0] nb);
    @(negedge clk);
    i72.in_valid = 1'b1; i72.in_data = d; i72.in_sop = sop; i72.in_eop = eop; i72.in_nbytes = nb;
    @(posedge clk); #1;
    i72.in_valid = 1'b0; i72.in_sop = 1'b0; i72.in_eop = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    repeat (2) tick();
    vectors++; if (co72 !== 16'h0000) begin miscompares++; $display("FAIL reset_crc_out72: got %h want 0000", co72); end
    vectors++; if (cv72 !== 1'b0) begin miscompares++; $display("FAIL reset_crc_valid72: got %b want 0", cv72); end
    vectors++; if (ok72 !== 1'b0) begin miscompares++; $display("FAIL reset_crc_ok72: got %b want 0", ok72); end
    vectors++; if (ab72 !== 1'b0) begin miscompares++; $display("FAIL reset_abort72: got %b want 0", ab72); end
    vectors++; if (bz72 !== 1'b0) begin miscompares++; $display("FAIL reset_busy72: got %b want 0", bz72); end
    vectors++; if (i72.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready72: got %b want 1", i72.in_ready); end
    vectors++; if ({cv32, ok32, ab32, bz32, i32.in_ready} !== 5'b00001) begin miscompares++; $display("FAIL reset_ctl32: got %b want 00001", {cv32, ok32, ab32, bz32, i32.in_ready}); end
    @(negedge clk); reset_L = 1'b1;
  endtask

  task automatic test_single_beat72;
    beat72(72'h313233343536373839, 1'b1, 1'b1, 4'd0);
    vectors++; if (cv72 !== 1'b1) begin miscompares++; $display("FAIL s72_valid: got %b want 1", cv72); end
    vectors++; if (co72 !== 16'hFEE8) begin miscompares++; $display("FAIL s72_crc: got %h want fee8", co72); end
    vectors++; if (ok72 !== 1'b0) begin miscompares++; $display("FAIL s72_ok: got %b want 0", ok72); end
    vectors++; if (bz72 !== 1'b0) begin miscompares++; $display("FAIL s72_busy: got %b want 0", bz72); end
    tick();
    vectors++; if (cv72 !== 1'b0) begin miscompares++; $display("FAIL s72_pulse: got %b want 0", cv72); end
    vectors++; if (co72 !== 16'hFEE8) begin miscompares++; $display("FAIL s72_hold: got %h want fee8", co72); end
    // nbytes above the beat size means a full beat
    beat72(72'h313233343536373839, 1'b1, 1'b1, 4'd15);
    vectors++; if ({cv72, i72.in_ready} !== 2'b11) begin miscompares++; $display("FAIL s72_nb15_ctl: got %b want 11", {cv72, i72.in_ready}); end
    vectors++; if (co72 !== 16'hFEE8) begin miscompares++; $display("FAIL s72_nb15_crc: got %h want fee8", co72); end
    // one valid byte 0x80 -> x^23 mod P
    beat72({8'h80, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, 1'b1, 4'd1);
    vectors++; if ({i72.in_ready, cv72, bz72} !== 3'b001) begin miscompares++; $display("FAIL s72_tail_ctl: got %b want 001", {i72.in_ready, cv72, bz72}); end
    tick();
    vectors++; if (cv72 !== 1'b1) begin miscompares++; $display("FAIL s72_tail_valid: got %b want 1", cv72); end
    vectors++; if (co72 !== 16'h8303) begin miscompares++; $display("FAIL s72_tail_crc: got %h want 8303", co72); end
  endtask

  task automatic test_stream_gapped8;
    int gap;
    beat8(8'hFF, 1'b0, 1'b1);
    vectors++; if ({bz8, cv8} !== 2'b00) begin miscompares++; $display("FAIL g8_drop: got %b want 00", {bz8, cv8}); end
    for (int i = 0; i < 9; i++) begin
      beat8(msg[i], i == 0, i == 8);
      if (i < 8) begin
        vectors++; if (bz8 !== 1'b1) begin miscompares++; $display("FAIL g8_busy beat %0d: got %b want 1", i, bz8); end
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          tick();
          vectors++; if ({bz8, cv8} !== 2'b10) begin miscompares++; $display("FAIL g8_gap_busy beat %0d: got %b want 10", i, {bz8, cv8}); end
        end
      end
    end
    vectors++; if ({cv8, bz8} !== 2'b10) begin miscompares++; $display("FAIL g8_done_ctl: got %b want 10", {cv8, bz8}); end
    vectors++; if (co8 !== 16'hFEE8) begin miscompares++; $display("FAIL g8_crc: got %h want fee8", co8); end
    tick();
    vectors++; if (cv8 !== 1'b0) begin miscompares++; $display("FAIL g8_pulse: got %b want 0", cv8); end
  endtask

  task automatic test_partial32;
    beat32(32'h31323334, 1'b1, 1'b0, 3'd0);
    beat32(32'h35363738, 1'b0, 1'b0, 3'd0);
    vectors++; if ({bz32, i32.in_ready} !== 2'b11) begin miscompares++; $display("FAIL p32_run: got %b want 11", {bz32, i32.in_ready}); end
    beat32(32'h39AABBCC, 1'b0, 1'b1, 3'd1);
    vectors++; if ({i32.in_ready, bz32, cv32} !== 3'b010) begin miscompares++; $display("FAIL p32_tail: got %b want 010", {i32.in_ready, bz32, cv32}); end
    tick();
    vectors++; if ({i32.in_ready, bz32, cv32} !== 3'b101) begin miscompares++; $display("FAIL p32_done: got %b want 101", {i32.in_ready, bz32, cv32}); end
    vectors++; if (co32 !== 16'hFEE8) begin miscompares++; $display("FAIL p32_crc: got %h want fee8", co32); end
    // two valid bytes 0x01,0x00 -> x^24 mod P, ready low two cycles
    beat32(32'h0100FFFF, 1'b1, 1'b1, 3'd2);
    vectors++; if ({i32.in_ready, cv32} !== 2'b00) begin miscompares++; $display("FAIL p32_k2_t1: got %b want 00", {i32.in_ready, cv32}); end
    tick();
    vectors++; if ({i32.in_ready, cv32} !== 2'b00) begin miscompares++; $display("FAIL p32_k2_t2: got %b want 00", {i32.in_ready, cv32}); end
    tick();
    vectors++; if (cv32 !== 1'b1) begin miscompares++; $display("FAIL p32_k2_valid: got %b want 1", cv32); end
    vectors++; if (co32 !== 16'h8603) begin miscompares++; $display("FAIL p32_k2_crc: got %h want 8603", co32); end
  endtask

  task automatic test_check8;
    for (int i = 0; i < 9; i++) beat8(msg[i], i == 0, 1'b0);
    beat8(8'hFE, 1'b0, 1'b0);
    beat8(8'hE8, 1'b0, 1'b1);
    vectors++; if ({cv8, ok8} !== 2'b11) begin miscompares++; $display("FAIL chk_good: got %b want 11", {cv8, ok8}); end
    vectors++; if (co8 !== 16'h0000) begin miscompares++; $display("FAIL chk_good_reg: got %h want 0000", co8); end
    beat8(8'h30, 1'b1, 1'b0);
    for (int i = 1; i < 9; i++) beat8(msg[i], 1'b0, 1'b0);
    beat8(8'hFE, 1'b0, 1'b0);
    beat8(8'hE8, 1'b0, 1'b1);
    vectors++; if ({cv8, ok8} !== 2'b10) begin miscompares++; $display("FAIL chk_bad: got %b want 10", {cv8, ok8}); end
  endtask

  task automatic test_abort8;
    beat8(8'h31, 1'b1, 1'b0);
    vectors++; if (ab8 !== 1'b0) begin miscompares++; $display("FAIL ab_first_sop: got %b want 0", ab8); end
    beat8(8'h32, 1'b0, 1'b0);
    beat8(8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      beat8(msg[i], i == 0, i == 8);
      if (i == 0) begin
        vectors++; if ({ab8, bz8} !== 2'b11) begin miscompares++; $display("FAIL ab_pulse: got %b want 11", {ab8, bz8}); end
      end
      if (i == 1) begin
        vectors++; if (ab8 !== 1'b0) begin miscompares++; $display("FAIL ab_one_cycle: got %b want 0", ab8); end
      end
    end
    vectors++; if ({cv8, co8} !== {1'b1, 16'hFEE8}) begin miscompares++; $display("FAIL ab_crc: got %b/%h want 1/fee8", cv8, co8); end
  endtask

  task automatic test_reset_mid8;
    beat8(8'h31, 1'b1, 1'b0);
    beat8(8'h32, 1'b0, 1'b0);
    vectors++; if (bz8 !== 1'b1) begin miscompares++; $display("FAIL rm_busy: got %b want 1", bz8); end
    #2 reset_L = 1'b0;
    #1;
    vectors++; if (co8 !== 16'h0000) begin miscompares++; $display("FAIL rm_crc_out: got %h want 0000", co8); end
    vectors++; if ({cv8, ok8, ab8, bz8, i8.in_ready} !== 5'b00001) begin miscompares++; $display("FAIL rm_ctl: got %b want 00001", {cv8, ok8, ab8, bz8, i8.in_ready}); end
    repeat (2) tick();
    vectors++; if (cv8 !== 1'b0) begin miscompares++; $display("FAIL rm_no_valid: got %b want 0", cv8); end
    @(negedge clk); reset_L = 1'b1;
    for (int i = 0; i < 9; i++) beat8(msg[i], i == 0, i == 8);
    vectors++; if ({cv8, co8} !== {1'b1, 16'hFEE8}) begin miscompares++; $display("FAIL rm_after: got %b/%h want 1/fee8", cv8, co8); end
  endtask

  task automatic test_back_to_back8;
    for (int i = 0; i < 9; i++) beat8(msg[i], i == 0, i == 8);
    vectors++; if ({cv8, co8} !== {1'b1, 16'hFEE8}) begin miscompares++; $display("FAIL b2b_first: got %b/%h want 1/fee8", cv8, co8); end
    beat8(8'h01, 1'b1, 1'b1);
    vectors++; if ({cv8, co8} !== {1'b1, 16'h8005}) begin miscompares++; $display("FAIL b2b_second: got %b/%h want 1/8005", cv8, co8); end
    tick();
    vectors++; if (cv8 !== 1'b0) begin miscompares++; $display("FAIL b2b_pulse: got %b want 0", cv8); end
  endtask

  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    i72.in_valid = 1'b0; i72.in_data = '0; i72.in_sop = 1'b0; i72.in_eop = 1'b0; i72.in_nbytes = '0;
    i8.in_valid = 1'b0; i8.in_data = '0; i8.in_sop = 1'b0; i8.in_eop = 1'b0; i8.in_nbytes = '0;
    i32.in_valid = 1'b0; i32.in_data = '0; i32.in_sop = 1'b0; i32.in_eop = 1'b0; i32.in_nbytes = '0;
    test_reset();
    test_single_beat72();
    test_stream_gapped8();
    test_partial32();
    test_check8();
    test_abort8();
    test_reset_mid8();
    test_back_to_back8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
